// File: rtl/mem_test_engine_if.sv
// Word-level memory port between mem_test_engine (master) and an axi_controller-style
// front end (slave): one request at a time, completed by mem_ready and acknowledged by mem_done.
interface mem_test_engine_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  logic              mem_read;
  logic [1:0]        mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_store;
  logic [DATA_W-1:0] mem_load;
  logic              mem_ready;
  logic              mem_done;

  modport master (
    output mem_read, mem_write, mem_addr, mem_store, mem_done,
    input  mem_load, mem_ready
  );

  modport slave (
    input  mem_read, mem_write, mem_addr, mem_store, mem_done,
    output mem_load, mem_ready
  );
endinterface

// File: rtl/mem_test_engine.sv
// Memory test sequencer: writes a generated pattern over a word range, reads it back and
// compares, repeating NUM_PASSES times with true/inverted data; reports pass/fail and first failure.
module mem_test_engine #(
  parameter int                DATA_W     = 32,
  parameter int                ADDR_W     = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR  = ADDR_W'(32'h0000_0020),
  parameter int                NUM_WORDS  = 16,
  parameter int                NUM_PASSES = 2,
  parameter logic [1:0]        WRITE_CODE = 2'b10,
  parameter int                ERR_W      = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                abort,
  input  logic [1:0]          mode,
  input  logic [DATA_W-1:0]   seed,
  mem_test_engine_if.master   mem,
  output logic                busy,
  output logic                run_done,
  output logic                pass,
  output logic [ERR_W-1:0]    err_count,
  output logic [ADDR_W-1:0]   fail_addr,
  output logic [DATA_W-1:0]   fail_exp,
  output logic [DATA_W-1:0]   fail_got
);

  localparam int IDX_W  = (NUM_WORDS  > 1) ? $clog2(NUM_WORDS)  : 1;
  localparam int PASS_W = (NUM_PASSES > 1) ? $clog2(NUM_PASSES) : 1;
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NUM_WORDS - 1);
  localparam logic [PASS_W-1:0] LAST_PASS = PASS_W'(NUM_PASSES - 1);
  localparam logic [DATA_W-1:0] LFSR_TAPS = DATA_W'(32'h8020_0003);
  localparam logic [DATA_W-1:0] ONE       = DATA_W'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_READ,
    S_NEXT_PASS,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  logic [1:0]        mode_q;
  logic [DATA_W-1:0] seed_q;
  logic [DATA_W-1:0] lfsr_q;
  logic [IDX_W-1:0]  idx_q;
  logic [PASS_W-1:0] pass_q;

  logic [ADDR_W-1:0] word_addr;
  logic [DATA_W-1:0] pat;
  logic [DATA_W-1:0] expected;
  logic [DATA_W-1:0] lfsr_init;
  logic [DATA_W-1:0] lfsr_step;
  logic              last_word;

  logic run_start;
  logic accept;
  logic pass_adv;
  logic run_end;

  assign last_word = (idx_q == LAST_IDX);
  assign word_addr = BASE_ADDR + (ADDR_W'(idx_q) << 2);
  assign lfsr_init = (seed_q == '0) ? ONE : seed_q;
  assign lfsr_step = (lfsr_q >> 1) ^ ({DATA_W{lfsr_q[0]}} & LFSR_TAPS);
  assign expected  = pat ^ {DATA_W{pass_q[0]}};

  always_comb begin
    pat = seed_q;
    case (mode_q)
      2'd1:    pat = DATA_W'(word_addr);
      2'd2:    pat = ONE << (32'(idx_q) % DATA_W);
      2'd3:    pat = lfsr_q;
      default: pat = seed_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d       = state_q;
    mem.mem_read  = 1'b0;
    mem.mem_write = 2'b00;
    mem.mem_addr  = '0;
    mem.mem_store = '0;
    mem.mem_done  = 1'b0;
    busy          = 1'b0;
    run_start     = 1'b0;
    accept        = 1'b0;
    pass_adv      = 1'b0;
    run_end       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          run_start = 1'b1;
          state_d   = S_WRITE;
        end
      end

      S_WRITE: begin
        busy          = 1'b1;
        mem.mem_write = WRITE_CODE;
        mem.mem_addr  = word_addr;
        mem.mem_store = expected;
        // Abort beats a completing transaction: it is left unacknowledged.
        if (abort) begin
          state_d = S_IDLE;
        end else if (mem.mem_ready) begin
          mem.mem_done = 1'b1;
          accept       = 1'b1;
          if (last_word) state_d = S_READ;
        end
      end

      S_READ: begin
        busy         = 1'b1;
        mem.mem_read = 1'b1;
        mem.mem_addr = word_addr;
        if (abort) begin
          state_d = S_IDLE;
        end else if (mem.mem_ready) begin
          mem.mem_done = 1'b1;
          accept       = 1'b1;
          if (last_word) state_d = S_NEXT_PASS;
        end
      end

      S_NEXT_PASS: begin
        busy = 1'b1;
        if (abort) begin
          state_d = S_IDLE;
        end else if (pass_q == LAST_PASS) begin
          run_end = 1'b1;
          state_d = S_DONE;
        end else begin
          pass_adv = 1'b1;
          state_d  = S_WRITE;
        end
      end

      S_DONE: state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q    <= '0;
      seed_q    <= '0;
      lfsr_q    <= '0;
      idx_q     <= '0;
      pass_q    <= '0;
      run_done  <= 1'b0;
      pass      <= 1'b0;
      err_count <= '0;
      fail_addr <= '0;
      fail_exp  <= '0;
      fail_got  <= '0;
    end else begin
      if (run_start) begin
        mode_q    <= mode;
        seed_q    <= seed;
        lfsr_q    <= (seed == '0) ? ONE : seed;
        idx_q     <= '0;
        pass_q    <= '0;
        run_done  <= 1'b0;
        pass      <= 1'b0;
        err_count <= '0;
        fail_addr <= '0;
        fail_exp  <= '0;
        fail_got  <= '0;
      end

      if (accept) begin
        idx_q  <= last_word ? '0 : idx_q + 1'b1;
        // Reload at every phase boundary so the read phase regenerates the written sequence.
        lfsr_q <= last_word ? lfsr_init : lfsr_step;
        if (state_q == S_READ && mem.mem_load != expected) begin
          if (err_count != '1) err_count <= err_count + 1'b1;
          if (err_count == '0) begin
            fail_addr <= word_addr;
            fail_exp  <= expected;
            fail_got  <= mem.mem_load;
          end
        end
      end

      if (pass_adv) pass_q <= pass_q + 1'b1;

      if (run_end) begin
        run_done <= 1'b1;
        pass     <= (err_count == '0);
      end
    end
  end

endmodule
